// File: rtl/imm_extend_stage_if.sv
// Decode-to-execute immediate handshake bundle: input side from decode, output side to execute.
// valid/ready: a beat transfers on a rising clock edge where valid and ready are both high; the sender
// holds valid and its payload steady until that edge, and ready never depends combinationally on valid.
interface imm_extend_stage_if #(
  parameter int TAG_W = 5
);
  logic             in_valid;
  logic             in_ready;
  logic [15:0]      in_imm;
  logic [1:0]       in_mode;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_data;
  logic [TAG_W-1:0] out_tag;

  modport master (
    output in_valid, in_imm, in_mode, in_tag, out_ready,
    input  in_ready, out_valid, out_data, out_tag
  );

  modport slave (
    input  in_valid, in_imm, in_mode, in_tag, out_ready,
    output in_ready, out_valid, out_data, out_tag
  );
endinterface

// File: rtl/imm_extend_stage.sv
// Registered immediate extender with a one-entry skid buffer and flush.
// Occupancy FSM (EMPTY/ONE/FULL) is visible on state_dbg.
module imm_extend_stage #(
  parameter int TAG_W = 5
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                flush,
  imm_extend_stage_if.slave   bus,
  output logic [1:0]          state_dbg
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_FULL  = 2'd3
  } occ_state_e;

  occ_state_e       state_q, state_d;
  logic [31:0]      ext_data;
  logic [31:0]      out_data_q, skid_data_q;
  logic [TAG_W-1:0] out_tag_q, skid_tag_q;
  logic             accept, fire;
  logic             load_out, out_from_skid, load_skid;

  always_comb begin
    ext_data = 32'h0;
    case (bus.in_mode)
      2'b00:   ext_data = {{16{bus.in_imm[15]}}, bus.in_imm};
      2'b01:   ext_data = {16'h0, bus.in_imm};
      2'b10:   ext_data = {bus.in_imm, 16'h0};
      default: ext_data = {{14{bus.in_imm[15]}}, bus.in_imm, 2'b00};
    endcase
  end

  // in_ready decodes the state register only, so it never waits on out_ready.
  assign bus.in_ready  = (state_q != S_FULL);
  assign bus.out_valid = (state_q != S_EMPTY);
  assign bus.out_data  = out_data_q;
  assign bus.out_tag   = out_tag_q;
  assign state_dbg     = state_q;

  assign accept = bus.in_valid & bus.in_ready;
  assign fire   = bus.out_valid & bus.out_ready;

  always_comb begin
    state_d       = state_q;
    load_out      = 1'b0;
    out_from_skid = 1'b0;
    load_skid     = 1'b0;
    if (flush) begin
      state_d = S_EMPTY;
    end else begin
      case (state_q)
        S_EMPTY: begin
          if (accept) begin
            state_d  = S_ONE;
            load_out = 1'b1;
          end
        end
        S_ONE: begin
          if (fire) begin
            state_d  = accept ? S_ONE : S_EMPTY;
            load_out = accept;
          end else if (accept) begin
            state_d   = S_FULL;
            load_skid = 1'b1;
          end
        end
        S_FULL: begin
          if (fire) begin
            state_d       = S_ONE;
            load_out      = 1'b1;
            out_from_skid = 1'b1;
          end
        end
        default: state_d = S_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= S_EMPTY;
    else          state_q <= state_d;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      out_data_q  <= 32'h0;
      out_tag_q   <= '0;
      skid_data_q <= 32'h0;
      skid_tag_q  <= '0;
    end else begin
      if (load_out) begin
        out_data_q <= out_from_skid ? skid_data_q : ext_data;
        out_tag_q  <= out_from_skid ? skid_tag_q  : bus.in_tag;
      end
      if (load_skid) begin
        skid_data_q <= ext_data;
        skid_tag_q  <= bus.in_tag;
      end
    end
  end

endmodule

// File: tb/tb_imm_extend_stage.sv
// Self-checking bench for imm_extend_stage: directed scenarios plus randomized streaming against a queue model.
module tb_imm_extend_stage;
  localparam int TAG_W = 5;

  logic       clock;
  logic       reset_n;
  logic       flush;
  logic [1:0] state_dbg;
  int         n_vec;
  int         n_err;
  logic [TAG_W+31:0] exp_q[$];

  imm_extend_stage_if #(.TAG_W(TAG_W)) bus ();

  imm_extend_stage #(.TAG_W(TAG_W)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .flush     (flush),
    .bus       (bus.slave),
    .state_dbg (state_dbg)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [31:0] ref_extend(input logic [15:0] imm, input logic [1:0] mode);
    int          s;
    logic [31:0] u;
    s = $signed(imm);
    u = {16'h0, imm};
    case (mode)
      2'd0:    return s;
      2'd1:    return u;
      2'd2:    return u * 32'd65536;
      default: return s * 4;
    endcase
  endfunction

  task automatic drive_idle();
    bus.in_valid  = 1'b0;
    bus.in_imm    = 16'h0;
    bus.in_mode   = 2'd0;
    bus.in_tag    = '0;
    flush         = 1'b0;
  endtask

  task automatic drive_in(input logic [15:0] imm, input logic [1:0] mode, input logic [TAG_W-1:0] tag);
    bus.in_valid = 1'b1;
    bus.in_imm   = imm;
    bus.in_mode  = mode;
    bus.in_tag   = tag;
  endtask

  task automatic test_reset();
    n_vec++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.out_data !== 32'h0 || bus.out_tag !== '0) begin
      n_err++;
      $display("FAIL reset: out_valid=%b in_ready=%b out_data=%h out_tag=%0d, want 0 1 00000000 0",
               bus.out_valid, bus.in_ready, bus.out_data, bus.out_tag);
    end
  endtask

  task automatic test_modes();
    logic [15:0] imm_tab [7];
    logic [1:0]  mode_tab[7];
    logic [31:0] want_tab[7];
    imm_tab  = '{16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'hFFFF, 16'h7FFF, 16'h1234};
    mode_tab = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd3, 2'd3, 2'd2};
    want_tab = '{32'hFFFF8000, 32'h00008000, 32'h80000000, 32'hFFFE0000,
                 32'hFFFFFFFC, 32'h0001FFFC, 32'h12340000};
    bus.out_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      @(negedge clock);
      n_vec++;
      if (bus.in_ready !== 1'b1) begin
        n_err++;
        $display("FAIL mode_in_ready[%0d]: got %b want 1", i, bus.in_ready);
      end
      drive_in(imm_tab[i], mode_tab[i], TAG_W'(i + 10));
      @(negedge clock);
      bus.in_valid = 1'b0;
      n_vec++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== want_tab[i] || bus.out_tag !== TAG_W'(i + 10)) begin
        n_err++;
        $display("FAIL mode_out[%0d]: valid=%b data=%h tag=%0d want 1 %h %0d",
                 i, bus.out_valid, bus.out_data, bus.out_tag, want_tab[i], i + 10);
      end
    end
    @(negedge clock);
    n_vec++;
    if (bus.out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL mode_drain: out_valid=%b want 0", bus.out_valid);
    end
  endtask

  task automatic test_backpressure();
    @(negedge clock);
    bus.out_ready = 1'b0;
    drive_in(16'h0001, 2'd1, TAG_W'(1));
    @(negedge clock);
    n_vec++;
    if (bus.out_valid !== 1'b1 || bus.out_tag !== TAG_W'(1) || bus.in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL bp_one: valid=%b tag=%0d in_ready=%b want 1 1 1", bus.out_valid, bus.out_tag, bus.in_ready);
    end
    drive_in(16'h0002, 2'd1, TAG_W'(2));
    @(negedge clock);
    n_vec++;
    if (bus.in_ready !== 1'b0 || bus.out_tag !== TAG_W'(1) || bus.out_data !== 32'h1) begin
      n_err++;
      $display("FAIL bp_full: in_ready=%b tag=%0d data=%h want 0 1 00000001", bus.in_ready, bus.out_tag, bus.out_data);
    end
    drive_in(16'h0003, 2'd1, TAG_W'(3));
    @(negedge clock);
    n_vec++;
    if (bus.in_ready !== 1'b0 || bus.out_tag !== TAG_W'(1) || bus.out_valid !== 1'b1) begin
      n_err++;
      $display("FAIL bp_hold: in_ready=%b tag=%0d valid=%b want 0 1 1", bus.in_ready, bus.out_tag, bus.out_valid);
    end
    bus.out_ready = 1'b1;
    @(negedge clock);
    n_vec++;
    if (bus.out_tag !== TAG_W'(2) || bus.out_data !== 32'h2 || bus.in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL bp_drain2: tag=%0d data=%h in_ready=%b want 2 00000002 1", bus.out_tag, bus.out_data, bus.in_ready);
    end
    @(negedge clock);
    bus.in_valid = 1'b0;
    n_vec++;
    if (bus.out_valid !== 1'b1 || bus.out_tag !== TAG_W'(3) || bus.out_data !== 32'h3) begin
      n_err++;
      $display("FAIL bp_drain3: valid=%b tag=%0d data=%h want 1 3 00000003", bus.out_valid, bus.out_tag, bus.out_data);
    end
    @(negedge clock);
    n_vec++;
    if (bus.out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL bp_empty: out_valid=%b want 0", bus.out_valid);
    end
  endtask

  task automatic test_streaming();
    int          sent;
    int          cycles;
    logic [15:0] imm;
    logic [1:0]  mode;
    logic [TAG_W-1:0] tag;
    logic [TAG_W+31:0] head;
    sent   = 0;
    cycles = 0;
    exp_q.delete();
    while ((sent < 100 || exp_q.size() != 0) && cycles < 3000) begin
      @(negedge clock);
      cycles++;
      n_vec++;
      if (bus.out_valid !== (exp_q.size() > 0) || bus.in_ready !== (exp_q.size() < 2)) begin
        n_err++;
        $display("FAIL stream_occ: out_valid=%b in_ready=%b want %b %b (held=%0d)",
                 bus.out_valid, bus.in_ready, exp_q.size() > 0, exp_q.size() < 2, exp_q.size());
      end
      if (bus.out_valid === 1'b1 && exp_q.size() > 0) begin
        head = exp_q[0];
        n_vec++;
        if (bus.out_data !== head[31:0] || bus.out_tag !== head[TAG_W+31:32]) begin
          n_err++;
          $display("FAIL stream_data: data=%h tag=%0d want %h %0d",
                   bus.out_data, bus.out_tag, head[31:0], head[TAG_W+31:32]);
        end
      end
      imm  = 16'($urandom);
      mode = 2'($urandom_range(0, 3));
      tag  = TAG_W'($urandom);
      bus.in_imm    = imm;
      bus.in_mode   = mode;
      bus.in_tag    = tag;
      bus.in_valid  = (sent < 100) && ($urandom_range(0, 3) != 0);
      bus.out_ready = ($urandom_range(0, 2) != 0);
      if (bus.out_valid === 1'b1 && bus.out_ready && exp_q.size() > 0) void'(exp_q.pop_front());
      if (bus.in_valid && bus.in_ready === 1'b1) begin
        exp_q.push_back({tag, ref_extend(imm, mode)});
        sent++;
      end
    end
    bus.in_valid = 1'b0;
    n_vec++;
    if (sent != 100 || exp_q.size() != 0) begin
      n_err++;
      $display("FAIL stream_timeout: sent=%0d pending=%0d want 100 0", sent, exp_q.size());
    end
  endtask

  task automatic test_flush();
    @(negedge clock);
    bus.out_ready = 1'b0;
    drive_in(16'h1111, 2'd0, TAG_W'(4));
    @(negedge clock);
    drive_in(16'h2222, 2'd0, TAG_W'(5));
    @(negedge clock);
    drive_in(16'h3333, 2'd0, TAG_W'(6));
    flush = 1'b1;
    @(negedge clock);
    flush = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    n_vec++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL flush_state: out_valid=%b in_ready=%b want 0 1", bus.out_valid, bus.in_ready);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      n_vec++;
      if (bus.out_valid !== 1'b0) begin
        n_err++;
        $display("FAIL flush_leak[%0d]: out_valid=%b tag=%0d want 0", i, bus.out_valid, bus.out_tag);
      end
    end
  endtask

  task automatic test_async_reset();
    @(negedge clock);
    bus.out_ready = 1'b0;
    drive_in(16'hABCD, 2'd1, TAG_W'(8));
    @(negedge clock);
    drive_in(16'hBCDE, 2'd1, TAG_W'(9));
    @(negedge clock);
    bus.in_valid = 1'b0;
    n_vec++;
    if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1) begin
      n_err++;
      $display("FAIL areset_fill: in_ready=%b out_valid=%b want 0 1", bus.in_ready, bus.out_valid);
    end
    #2;
    reset_n = 1'b0;
    #1;
    n_vec++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.out_data !== 32'h0 || bus.out_tag !== '0) begin
      n_err++;
      $display("FAIL areset_now: out_valid=%b in_ready=%b data=%h tag=%0d want 0 1 00000000 0",
               bus.out_valid, bus.in_ready, bus.out_data, bus.out_tag);
    end
    @(negedge clock);
    reset_n       = 1'b1;
    bus.out_ready = 1'b1;
    drive_in(16'hF00D, 2'd2, TAG_W'(17));
    @(negedge clock);
    bus.in_valid = 1'b0;
    n_vec++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 32'hF00D0000 || bus.out_tag !== TAG_W'(17)) begin
      n_err++;
      $display("FAIL areset_resume: valid=%b data=%h tag=%0d want 1 f00d0000 17", bus.out_valid, bus.out_data, bus.out_tag);
    end
    @(negedge clock);
    n_vec++;
    if (bus.out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL areset_empty: out_valid=%b want 0", bus.out_valid);
    end
  endtask

  initial begin
    n_vec   = 0;
    n_err   = 0;
    reset_n = 1'b0;
    bus.out_ready = 1'b0;
    drive_idle();
    #2;
    test_reset();
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    test_modes();
    test_backpressure();
    test_streaming();
    test_flush();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
